// File: rtl/banked_memory.sv
//==============================================================================
// Module   : banked_memory
// Brief    : Byte-addressable 32-bit memory with fixed-latency request/ready
//            access, sub-word load extension and a combinational debug port.
// Revision : 1.0
//==============================================================================
`default_nettype none

module banked_memory #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int DBG_AW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              ready,
    output logic              err,
    input  logic [DBG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int c_AW = $clog2(DEPTH);

    if (DATA_W != 32) begin : g_chk_data_w
        $error("banked_memory: DATA_W must be 32");
    end
    if ((DEPTH < 16) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("banked_memory: DEPTH must be a power of 2 in 16..65536");
    end
    if ((LATENCY < 0) || (LATENCY > 7)) begin : g_chk_latency
        $error("banked_memory: LATENCY must be 0..7");
    end
    if ((DBG_AW < 1) || (DBG_AW > c_AW)) begin : g_chk_dbg_aw
        $error("banked_memory: DBG_AW must be 1..log2(DEPTH)");
    end

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Final count value of the wait-state counter; unused when LATENCY is 0.
    localparam logic [2:0] c_LAST = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [2:0]        r_cnt;
    logic [31:0]       r_addr;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [31:0]       r_wdata;
    logic              r_ready;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_range_err;
    logic              w_align_err;
    logic              w_err;
    logic [c_AW-1:0]   w_idx;
    logic [31:0]       w_word;
    logic [15:0]       w_lane;
    logic [31:0]       w_load;
    logic [3:0]        w_be;
    logic [31:0]       w_wlane;
    logic              w_in_resp;
    logic [c_AW-1:0]   w_dbg_idx;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (req) w_next_state = (LATENCY == 0) ? c_RESP : c_WAIT;
            c_WAIT:  if (r_cnt == c_LAST) w_next_state = c_RESP;
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if ((r_state == c_WAIT) && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= 3'd0;
        end
    end

    // The access is frozen at accept; later input activity cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_sign  <= 1'b0;
            r_wdata <= 32'd0;
        end else if ((r_state == c_IDLE) && req) begin
            r_addr  <= addr;
            r_we    <= we;
            r_size  <= size;
            r_sign  <= sign;
            r_wdata <= w_data;
        end
    end

    assign w_range_err = |r_addr[31:c_AW+2];

    always_comb begin
        w_align_err = 1'b0;
        case (r_size)
            2'b01:   w_align_err = r_addr[0];
            2'b10:   w_align_err = |r_addr[1:0];
            default: w_align_err = 1'b0;
        endcase
    end

    assign w_err     = w_range_err || w_align_err || (r_size == 2'b11);
    assign w_idx     = r_addr[c_AW+1:2];
    assign w_word    = r_mem[w_idx];
    assign w_lane    = 16'(w_word >> {r_addr[1:0], 3'b000});
    assign w_in_resp = (r_state == c_RESP);

    always_comb begin
        w_load = w_word;
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load = {{16{r_sign & w_lane[15]}}, w_lane[15:0]};
            default: w_load = w_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_in_resp && r_we && !w_err) begin
            for (int n = 0; n < 4; n++) begin
                if (w_be[n]) r_mem[w_idx][8*n +: 8] <= w_wlane[8*n +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= w_in_resp;
            r_err   <= w_in_resp && w_err;
            if (w_in_resp && !r_we && !w_err) r_rdata <= w_load;
        end
    end

    assign w_dbg_idx = c_AW'(dbg_addr);
    assign dbg_data  = r_mem[w_dbg_idx];
    assign r_data    = r_rdata;
    assign ready     = r_ready;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_banked_memory.sv
//==============================================================================
// Module   : tb_banked_memory
// Brief    : Randomized self-checking bench for banked_memory against a
//            byte-array reference model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_banked_memory;

    localparam int c_LAT   = 2;
    localparam int c_DEPTH = 1024;
    localparam int c_DBGAW = 8;

    logic              clk;
    logic              rst;
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [1:0]        size;
    logic              sign;
    logic [31:0]       w_data;
    logic [31:0]       r_data;
    logic              ready;
    logic              err;
    logic [c_DBGAW-1:0] dbg_addr;
    logic [31:0]       dbg_data;

    int                n_cmp;
    int                n_bad;
    logic [7:0]        mm [4*c_DEPTH];
    logic [31:0]       m_rdata;

    banked_memory #(
        .DATA_W  (32),
        .DEPTH   (c_DEPTH),
        .LATENCY (c_LAT),
        .DBG_AW  (c_DBGAW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .size     (size),
        .sign     (sign),
        .w_data   (w_data),
        .r_data   (r_data),
        .ready    (ready),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
        int nb;
        if (s == 2'b11) return 1'b1;
        nb = 1 << s;
        if ((a % 32'(nb)) != 32'd0) return 1'b1;
        if (a >= 32'(4 * c_DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        int nb;
        logic [31:0] v;
        nb = 1 << s;
        v  = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mm[a + 32'(i)]) << (8 * i));
        if ((nb < 4) && sg && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int nb;
        nb = 1 << s;
        for (int i = 0; i < nb; i++) mm[a + 32'(i)] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {mm[4*idx+3], mm[4*idx+2], mm[4*idx+1], mm[4*idx]};
    endfunction

    // One complete access; inputs are scrambled right after accept.
    task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] d, input string tag);
        int   lat;
        logic e;
        req = 1'b1; we = w; addr = a; size = s; sign = sg; w_data = d;
        @(posedge clk); #1;
        req    = 1'b0;
        we     = 1'($urandom);
        addr   = $urandom;
        size   = 2'($urandom);
        sign   = 1'($urandom);
        w_data = $urandom;
        lat = 0;
        while ((ready !== 1'b1) && (lat < 20)) begin
            @(posedge clk); #1;
            lat++;
        end
        e = model_err(a, s);
        if (!e) begin
            if (w) model_store(a, s, d);
            else   m_rdata = model_load(a, s, sg);
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(c_LAT + 1));
        check_eq({tag, " err"}, 32'(err), 32'(e));
        check_eq({tag, " r_data"}, r_data, m_rdata);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; m_rdata = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; size = 2'd0;
        sign = 1'b0; w_data = 32'd0; dbg_addr = '0;
        req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        check_eq("reset ready", 32'(ready), 32'd0);
        check_eq("reset err", 32'(err), 32'd0);
        check_eq("reset r_data", r_data, 32'd0);
        rst = 1'b0;

        access(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, "st_word");
        access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "ld_word");
        check_eq("ld_word value", r_data, 32'hDEADBEEF);
        access(1'b1, 32'h11, 2'b00, 1'b0, 32'h80, "st_byte");
        access(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, "ld_sbyte");
        check_eq("ld_sbyte value", r_data, 32'hFFFFFF80);
        access(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, "ld_ubyte");
        check_eq("ld_ubyte value", r_data, 32'h00000080);
        dbg_addr = 8'd4; #1;
        check_eq("dbg word4", dbg_data, 32'hDEAD80EF);

        access(1'b1, 32'h13, 2'b01, 1'b0, 32'h1234, "st_half_mis");
        check_eq("st_half_mis err set", 32'(err), 32'd1);
        check_eq("st_half_mis mem", dbg_data, 32'hDEAD80EF);
        check_eq("st_half_mis r_data", r_data, 32'h00000080);
        access(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, "ld_oob");
        check_eq("ld_oob err set", 32'(err), 32'd1);
        check_eq("ld_oob r_data", r_data, 32'h00000080);

        for (int i = 0; i < 16; i++) access(1'b1, 32'(4 * i), 2'b10, 1'b0, $urandom, "init");

        // Held request: four back-to-back loads.
        begin
            logic [31:0] la [4];
            int c, nr;
            la[0] = 32'h00; la[1] = 32'h14; la[2] = 32'h28; la[3] = 32'h3C;
            c = 0; nr = 0;
            req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; addr = la[0];
            while (c < 30) begin
                @(posedge clk); #1;
                c++;
                if (ready === 1'b1) begin
                    nr++;
                    check_eq("held spacing", 32'(c), 32'(4 * nr));
                    if (nr <= 4) begin
                        m_rdata = model_load(la[nr-1], 2'b10, 1'b0);
                        check_eq("held r_data", r_data, m_rdata);
                    end
                    if (nr < 4) addr = la[nr];
                    else        req  = 1'b0;
                end
            end
            check_eq("held count", 32'(nr), 32'd4);
        end

        // Reset during the wait state aborts a store.
        begin
            logic [31:0] old;
            int nr;
            dbg_addr = 8'd8;
            old = model_word(8);
            req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'b10; w_data = 32'hCAFEF00D;
            @(posedge clk); #1;
            req = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            nr = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (ready === 1'b1) nr++;
            end
            check_eq("abort no ready", 32'(nr), 32'd0);
            check_eq("abort mem kept", dbg_data, old);
            m_rdata = 32'd0;
            check_eq("abort r_data cleared", r_data, m_rdata);
            access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "post_rst_ld");
            check_eq("post_rst_ld value", r_data, old);
        end

        for (int k = 0; k < 300; k++) begin
            logic        w;
            logic [1:0]  s;
            logic [31:0] a;
            int          di;
            w = 1'($urandom);
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 | $urandom;
            else                           a = 32'($urandom_range(0, 63));
            di = $urandom_range(0, 15);
            dbg_addr = 8'(di);
            access(w, a, s, 1'($urandom), $urandom, "rand");
            check_eq("rand dbg", dbg_data, model_word(di));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
